// File: rtl/banked_osc_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : banked_osc_fsm
//  Description : Moore {bank, phase} oscillator. Steps the phase within the
//                current bank when enabled, or moves to the neighbouring bank
//                (direction selectable) when a switch is requested. Supports
//                synchronous load and registered wrap / bank-change pulses.
//                Optional macro SW_EDGE_EN: switch request is edge-detected
//                (one switch per rising edge of sw) instead of level-sensitive.
//  Revision    : 1.0  initial release
// ============================================================================
module banked_osc_fsm #(
   parameter int NUM_BANKS = 2,
   parameter int PHASES    = 2,
   localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   localparam int PHASE_W  = (PHASES > 1) ? $clog2(PHASES) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      sw,
   input  logic                      dir,
   input  logic                      ld,
   input  logic [BANK_W-1:0]         ld_bank,
   input  logic [PHASE_W-1:0]        ld_phase,
   output logic [BANK_W+PHASE_W-1:0] state_out,
   output logic                      y,
   output logic                      wrap,
   output logic                      bank_chg
);

   localparam logic [BANK_W-1:0]  c_BANK_MAX  = BANK_W'(NUM_BANKS - 1);
   localparam logic [BANK_W-1:0]  c_BANK_ONE  = BANK_W'(1);
   localparam logic [PHASE_W-1:0] c_PHASE_MAX = PHASE_W'(PHASES - 1);
   localparam logic [PHASE_W-1:0] c_PHASE_ONE = PHASE_W'(1);

   logic [BANK_W-1:0]  bank_q,  bank_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic               y_q,        y_d;
   logic               wrap_q,     wrap_d;
   logic               bank_chg_q, bank_chg_d;
   logic               w_sw_act;
   logic               w_bad_state;

`ifdef SW_EDGE_EN
   logic sw_q;

   // Track previous sw every cycle so a rising edge seen while disabled is lost
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sw_q <= 1'b0;
      else     sw_q <= sw;
   end

   assign w_sw_act = sw & ~sw_q;
`else
   assign w_sw_act = sw;
`endif

   // Encodings past the last bank/phase are unreachable except by upset
   assign w_bad_state = (bank_q > c_BANK_MAX) || (phase_q > c_PHASE_MAX);

   // Next-state and pulse decode: load beats switch beats step beats hold
   always_comb begin
      bank_d     = bank_q;
      phase_d    = phase_q;
      wrap_d     = 1'b0;
      bank_chg_d = 1'b0;
      if (ld) begin
         bank_d  = (ld_bank  > c_BANK_MAX)  ? '0 : ld_bank;
         phase_d = (ld_phase > c_PHASE_MAX) ? '0 : ld_phase;
      end else if (w_bad_state) begin
         bank_d  = '0;
         phase_d = '0;
      end else if (en && w_sw_act) begin
         if (dir) bank_d = (bank_q == '0) ? c_BANK_MAX : (bank_q - c_BANK_ONE);
         else     bank_d = (bank_q == c_BANK_MAX) ? '0 : (bank_q + c_BANK_ONE);
         bank_chg_d = 1'b1;
      end else if (en) begin
         if (phase_q == c_PHASE_MAX) begin
            phase_d = '0;
            wrap_d  = 1'b1;
         end else begin
            phase_d = phase_q + c_PHASE_ONE;
         end
      end
      y_d = (phase_d == c_PHASE_MAX);
   end

   // State and registered outputs; y is decoded from the next phase so it
   // lines up with the state it describes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_q     <= '0;
         phase_q    <= '0;
         y_q        <= 1'b0;
         wrap_q     <= 1'b0;
         bank_chg_q <= 1'b0;
      end else begin
         bank_q     <= bank_d;
         phase_q    <= phase_d;
         y_q        <= y_d;
         wrap_q     <= wrap_d;
         bank_chg_q <= bank_chg_d;
      end
   end

   assign state_out = {bank_q, phase_q};
   assign y         = y_q;
   assign wrap      = wrap_q;
   assign bank_chg  = bank_chg_q;

endmodule
`default_nettype wire
